round_timer_scorer: RTL and testbench

//  Upstream producer of gameOver for the game-mode FSM; consumes its ingameOn level.

---
 rtl/round_timer_scorer_pkg.sv | 23 ++
 rtl/bcd_sec_down_counter.sv | 42 ++++
 rtl/round_timer_scorer.sv | 129 ++++++++++++
 tb/tb_round_timer_scorer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/round_timer_scorer_pkg.sv
// Shared types and defaults for the round timer / pair scorer.
// Holds the FSM state encoding and BCD helper functions.
package round_timer_scorer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam int CLK_HZ_DEFAULT        = 50_000_000;
    localparam int ROUND_SECONDS_DEFAULT = 60;
    localparam int NUM_PAIRS_DEFAULT     = 8;

    function automatic logic [3:0] tensOf(input int s);
        return 4'(s / 10);
    endfunction

    function automatic logic [3:0] onesOf(input int s);
        return 4'(s % 10);
    endfunction

endpackage

// File: rtl/bcd_sec_down_counter.sv
// Two-digit BCD seconds down-counter with reload.
// Ports: CLOCK_50, resetn, load, dec -> secTens, secOnes, isOne (value == 01).
module bcd_sec_down_counter
    import round_timer_scorer_pkg::*;
#(
    parameter int ROUND_SECONDS = ROUND_SECONDS_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       load,
    input  logic       dec,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       isOne
);

    localparam logic [3:0] LOAD_TENS = tensOf(ROUND_SECONDS);
    localparam logic [3:0] LOAD_ONES = onesOf(ROUND_SECONDS);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            secTens <= LOAD_TENS;
            secOnes <= LOAD_ONES;
        end else if (load) begin
            secTens <= LOAD_TENS;
            secOnes <= LOAD_ONES;
        end else if (dec) begin
            if (secOnes == 4'd0) begin
                // borrow from tens; 00 simply holds
                if (secTens != 4'd0) begin
                    secTens <= secTens - 4'd1;
                    secOnes <= 4'd9;
                end
            end else begin
                secOnes <= secOnes - 4'd1;
            end
        end
    end

    assign isOne = (secTens == 4'd0) && (secOnes == 4'd1);

endmodule

// File: rtl/round_timer_scorer.sv
// Round timer and matched-pair scorer; ends the round on time-out or win.
// Ports: CLOCK_50, resetn, ingameOn, pairMatched -> gameOver, timeUp, winFlag, secTens, secOnes, pairCount.
module round_timer_scorer
    import round_timer_scorer_pkg::*;
#(
    parameter int CLK_HZ        = CLK_HZ_DEFAULT,
    parameter int ROUND_SECONDS = ROUND_SECONDS_DEFAULT,
    parameter int NUM_PAIRS     = NUM_PAIRS_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ingameOn,
    input  logic       pairMatched,
    output logic       gameOver,
    output logic       timeUp,
    output logic       winFlag,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic [3:0] pairCount
);

    // guard keeps a 1-bit prescaler legal when CLK_HZ == 1
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]    NP   = 4'(NUM_PAIRS);

    state_t          state, stateNext;
    logic [PW-1:0]   prescaler, presNext;
    logic [3:0]      pairNext;
    logic            goNext, upNext, winNext;
    logic            load, dec, isOne, tick, winHit;

    bcd_sec_down_counter #(
        .ROUND_SECONDS(ROUND_SECONDS)
    ) uSec (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .load    (load),
        .dec     (dec),
        .secTens (secTens),
        .secOnes (secOnes),
        .isOne   (isOne)
    );

    assign tick = (state == S_RUNNING) && (prescaler == PMAX);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            prescaler <= '0;
            pairCount <= 4'd0;
            gameOver  <= 1'b0;
            timeUp    <= 1'b0;
            winFlag   <= 1'b0;
        end else begin
            state     <= stateNext;
            prescaler <= presNext;
            pairCount <= pairNext;
            gameOver  <= goNext;
            timeUp    <= upNext;
            winFlag   <= winNext;
        end
    end

    always_comb begin
        stateNext = state;
        presNext  = prescaler;
        pairNext  = pairCount;
        goNext    = 1'b0;
        upNext    = timeUp;
        winNext   = winFlag;
        load      = 1'b0;
        dec       = 1'b0;
        winHit    = 1'b0;
        unique case (state)
            S_IDLE: begin
                load     = 1'b1;
                presNext = '0;
                pairNext = 4'd0;
                upNext   = 1'b0;
                winNext  = 1'b0;
                if (ingameOn) stateNext = S_RUNNING;
            end
            S_RUNNING: begin
                if (!ingameOn) begin
                    stateNext = S_IDLE;
                    load      = 1'b1;
                    presNext  = '0;
                    pairNext  = 4'd0;
                    upNext    = 1'b0;
                    winNext   = 1'b0;
                end else begin
                    presNext = tick ? '0 : prescaler + 1'b1;
                    winHit   = pairMatched &&
                               (5'(pairCount) + 5'd1 == 5'(NP));
                    if (pairMatched && pairCount != NP)
                        pairNext = pairCount + 4'd1;
                    // a win on the final tick pre-empts the decrement
                    if (winHit) begin
                        stateNext = S_DONE;
                        winNext   = 1'b1;
                        goNext    = 1'b1;
                    end else if (tick) begin
                        dec = 1'b1;
                        if (isOne) begin
                            stateNext = S_DONE;
                            upNext    = 1'b1;
                            goNext    = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!ingameOn) begin
                    stateNext = S_IDLE;
                    load      = 1'b1;
                    presNext  = '0;
                    pairNext  = 4'd0;
                    upNext    = 1'b0;
                    winNext   = 1'b0;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_round_timer_scorer.sv
// Bench for round_timer_scorer: directed vector table, hand sequences, random vs model.
// Runs with CLK_HZ=10, ROUND_SECONDS=3, NUM_PAIRS=2.
module tb_round_timer_scorer;

    localparam int CHZ = 10;
    localparam int RS  = 3;
    localparam int NP  = 2;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       ingameOn = 1'b0;
    logic       pairMatched = 1'b0;
    logic       gameOver, timeUp, winFlag;
    logic [3:0] secTens, secOnes, pairCount;

    int checks   = 0;
    int failures = 0;

    round_timer_scorer #(
        .CLK_HZ(CHZ), .ROUND_SECONDS(RS), .NUM_PAIRS(NP)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .ingameOn   (ingameOn),
        .pairMatched(pairMatched),
        .gameOver   (gameOver),
        .timeUp     (timeUp),
        .winFlag    (winFlag),
        .secTens    (secTens),
        .secOnes    (secOnes),
        .pairCount  (pairCount)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // reference model: remaining seconds as an integer, elapsed cycles in round
    int mSec, mPairs, mElapsed;
    bit mActive, mEnded, mGo, mUp, mWin;

    function automatic void modelReset();
        mSec = RS; mPairs = 0; mElapsed = 0;
        mActive = 0; mEnded = 0; mGo = 0; mUp = 0; mWin = 0;
    endfunction

    function automatic void modelEdge(input bit ig, input bit pm);
        bit win, tk;
        mGo = 0;
        if (mActive) begin
            if (!ig) begin
                modelReset();
            end else begin
                mElapsed++;
                tk  = (mElapsed % CHZ) == 0;
                win = pm && (mPairs + 1 == NP);
                if (pm && mPairs < NP) mPairs++;
                if (win) begin
                    mActive = 0; mEnded = 1; mWin = 1; mGo = 1;
                end else if (tk) begin
                    mSec--;
                    if (mSec == 0) begin
                        mActive = 0; mEnded = 1; mUp = 1; mGo = 1;
                    end
                end
            end
        end else if (mEnded) begin
            if (!ig) modelReset();
        end else if (ig) begin
            mActive = 1; mElapsed = 0;
        end
    endfunction

    task automatic checkOut(input string nm, input int sec, input int pairs,
                            input bit go, input bit up, input bit win);
        checks++;
        if (secTens !== 4'(sec / 10) || secOnes !== 4'(sec % 10) ||
            pairCount !== 4'(pairs) || gameOver !== go ||
            timeUp !== up || winFlag !== win) begin
            failures++;
            $display("FAIL %s: got sec=%0d%0d pairs=%0d go=%0b up=%0b win=%0b, expected sec=%0d pairs=%0d go=%0b up=%0b win=%0b",
                     nm, secTens, secOnes, pairCount, gameOver, timeUp, winFlag,
                     sec, pairs, go, up, win);
        end
    endtask

    task automatic step(input bit ig, input bit pm);
        ingameOn = ig;
        pairMatched = pm;
        @(posedge CLOCK_50);
        modelEdge(ig, pm);
        #1;
    endtask

    typedef struct {
        bit    ig;
        bit    pm;
        int    n;
        int    sec;
        int    pairs;
        bit    go;
        bit    up;
        bit    win;
        string nm;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input bit ig, input bit pm, input int n,
                                 input int sec, input int pairs, input bit go,
                                 input bit up, input bit win, input string nm);
        vec_t v;
        v.ig = ig; v.pm = pm; v.n = n; v.sec = sec; v.pairs = pairs;
        v.go = go; v.up = up; v.win = win; v.nm = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        modelReset();
        // time-out
        addv(1, 0, 1, 3, 0, 0, 0, 0, "to_enter");
        addv(1, 0, 9, 3, 0, 0, 0, 0, "to_pre1");
        addv(1, 0, 1, 2, 0, 0, 0, 0, "to_02");
        addv(1, 0, 9, 2, 0, 0, 0, 0, "to_pre2");
        addv(1, 0, 1, 1, 0, 0, 0, 0, "to_01");
        addv(1, 0, 9, 1, 0, 0, 0, 0, "to_pre3");
        addv(1, 0, 1, 0, 0, 1, 1, 0, "to_00_go");
        addv(1, 0, 1, 0, 0, 0, 1, 0, "to_go_drop");
        addv(1, 0, 5, 0, 0, 0, 1, 0, "to_hold");
        addv(0, 0, 1, 3, 0, 0, 0, 0, "to_reload");
        // win, then DONE hold
        addv(1, 0, 1, 3, 0, 0, 0, 0, "win_enter");
        addv(1, 1, 1, 3, 1, 0, 0, 0, "win_p1");
        addv(1, 0, 3, 3, 1, 0, 0, 0, "win_gap");
        addv(1, 1, 1, 3, 2, 1, 0, 1, "win_p2_go");
        addv(1, 0, 1, 3, 2, 0, 0, 1, "win_go_drop");
        addv(1, 1, 3, 3, 2, 0, 0, 1, "done_extra_pm");
        addv(1, 0, 20, 3, 2, 0, 0, 1, "done_no_tick");
        addv(0, 0, 1, 3, 0, 0, 0, 0, "done_reload");
        // final pair on final tick
        addv(1, 0, 1, 3, 0, 0, 0, 0, "sim_enter");
        addv(1, 1, 1, 3, 1, 0, 0, 0, "sim_p1");
        addv(1, 0, 28, 1, 1, 0, 0, 0, "sim_wait");
        addv(1, 1, 1, 1, 2, 1, 0, 1, "sim_both");
        addv(0, 0, 1, 3, 0, 0, 0, 0, "sim_reload");
        // non-final pair on a tick: both update
        addv(1, 0, 1, 3, 0, 0, 0, 0, "nf_enter");
        addv(1, 0, 9, 3, 0, 0, 0, 0, "nf_wait");
        addv(1, 1, 1, 2, 1, 0, 0, 0, "nf_both");
        // quit at 02, then restart
        addv(1, 0, 4, 2, 1, 0, 0, 0, "q_run");
        addv(0, 0, 1, 3, 0, 0, 0, 0, "q_quit");
        addv(0, 1, 2, 3, 0, 0, 0, 0, "q_idle_pm");
        addv(1, 0, 1, 3, 0, 0, 0, 0, "q_reenter");
        addv(1, 0, 9, 3, 0, 0, 0, 0, "q_full1");
        addv(1, 0, 1, 2, 0, 0, 0, 0, "q_full2");
        addv(0, 0, 1, 3, 0, 0, 0, 0, "q_exit");

        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOut("reset_state", 3, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        modelReset();

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++)
                step(vecs[i].ig, vecs[i].pm);
            checkOut(vecs[i].nm, vecs[i].sec, vecs[i].pairs,
                     vecs[i].go, vecs[i].up, vecs[i].win);
        end

        // async reset between edges mid-round
        for (int k = 0; k < 12; k++) step(1, 0);
        step(1, 1);
        checkOut("pre_reset", 2, 1, 0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        checkOut("async_reset", 3, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        modelReset();
        step(1, 0);
        checkOut("post_reset", 3, 0, 0, 0, 0);
        step(1, 0);
        checkOut("post_reset_nogo", 3, 0, 0, 0, 0);
        step(0, 0);
        modelReset();

        // random stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            bit ig, pm;
            ig = ($urandom_range(0, 99) < 97);
            pm = ($urandom_range(0, 99) < 6);
            step(ig, pm);
            checkOut("rand", mSec, mPairs, mGo, mUp, mWin);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
